// File: rtl/input_synchronizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_synchronizer_pkg
// Description : Shared constants for the traffic-light input synchronizers.
// Revision    : 1.0 - initial release
// ============================================================================
package input_synchronizer_pkg;

    // Default depth of every synchronizer chain (two flops is the usual
    // trade-off between MTBF and latency at this clock rate).
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage : input_synchronizer_pkg
`default_nettype wire

// File: rtl/input_synchronizer_sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : Single-bit multi-flop synchronizer with asynchronous reset to
//               a configurable value. Used both for data inputs (reset to 0)
//               and as a reset bridge (reset to 1, d tied low).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain
    import input_synchronizer_pkg::*;
#(
    parameter int   STAGES      = DEFAULT_SYNC_STAGES,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic Reset,
    input  logic d,
    output logic q
);

    // Depths below two give no metastability protection; above four only
    // adds latency for no practical MTBF gain.
    generate
        if ((STAGES < 2) || (STAGES > 4)) begin : g_bad_stages
            $error("sync_chain: STAGES must be in the range 2..4");
        end
    endgenerate

    // Flops are marked so synthesis keeps them adjacent and never retimes
    // logic between them; nothing but wire sits between stages.
    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *)
    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Next state: shift the raw input into stage 0, move every stage up one.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    // Chain register: asynchronous reset forces every stage to RESET_VALUE.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            chain_q <= {STAGES{RESET_VALUE}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/input_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : input_synchronizer
// Description : Brings Reset, Sensor, Walk_Request and Reprogram into the clk
//               domain. Data inputs go through independent synchronizer
//               chains; Reset drives a reset bridge (async assert, sync
//               deassert) whose output Reset_Sync feeds downstream logic.
// Revision    : 1.0 - initial release
// ============================================================================
module input_synchronizer
    import input_synchronizer_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic Reset,
    input  logic Sensor,
    input  logic Walk_Request,
    input  logic Reprogram,
    output logic Prog_Sync,
    output logic WR_Sync,
    output logic Sensor_Sync,
    output logic Reset_Sync
);

    // Car sensor: level copy, cleared while Reset is high.
    sync_chain #(
        .STAGES      (STAGES),
        .RESET_VALUE (1'b0)
    ) u_sensor_sync (
        .clk   (clk),
        .Reset (Reset),
        .d     (Sensor),
        .q     (Sensor_Sync)
    );

    // Pedestrian walk button: level copy, no stretching; short presses may
    // be lost and must be held by the walk register downstream.
    sync_chain #(
        .STAGES      (STAGES),
        .RESET_VALUE (1'b0)
    ) u_walk_sync (
        .clk   (clk),
        .Reset (Reset),
        .d     (Walk_Request),
        .q     (WR_Sync)
    );

    // Timing reprogram request.
    sync_chain #(
        .STAGES      (STAGES),
        .RESET_VALUE (1'b0)
    ) u_prog_sync (
        .clk   (clk),
        .Reset (Reset),
        .d     (Reprogram),
        .q     (Prog_Sync)
    );

    // Reset bridge: all stages set asynchronously by Reset, then zeros shift
    // through after release so Reset_Sync drops cleanly on a clock edge.
    // Data chains release on the same edges, so downstream logic must gate
    // on Reset_Sync rather than trust the data outputs during release.
    sync_chain #(
        .STAGES      (STAGES),
        .RESET_VALUE (1'b1)
    ) u_reset_bridge (
        .clk   (clk),
        .Reset (Reset),
        .d     (1'b0),
        .q     (Reset_Sync)
    );

endmodule : input_synchronizer
`default_nettype wire

// File: tb/tb_input_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_synchronizer
// Description : Self-checking bench for input_synchronizer. Runs a STAGES=2
//               and a STAGES=3 instance from the same directed stimulus and
//               checks both against an edge-indexed model every cycle, plus
//               hand-computed expectations at key instants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_synchronizer;

    logic clk = 1'b0;
    logic Reset = 1'b0;
    logic Sensor = 1'b0;
    logic Walk_Request = 1'b0;
    logic Reprogram = 1'b0;

    logic p2, w2, s2, r2;
    logic p3, w3, s3, r3;

    int total = 0;
    int bad   = 0;

    // 10 ns clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    input_synchronizer #(.STAGES(2)) u_dut2 (
        .clk          (clk),
        .Reset        (Reset),
        .Sensor       (Sensor),
        .Walk_Request (Walk_Request),
        .Reprogram    (Reprogram),
        .Prog_Sync    (p2),
        .WR_Sync      (w2),
        .Sensor_Sync  (s2),
        .Reset_Sync   (r2)
    );

    input_synchronizer #(.STAGES(3)) u_dut3 (
        .clk          (clk),
        .Reset        (Reset),
        .Sensor       (Sensor),
        .Walk_Request (Walk_Request),
        .Reprogram    (Reprogram),
        .Prog_Sync    (p3),
        .WR_Sync      (w3),
        .Sensor_Sync  (s3),
        .Reset_Sync   (r3)
    );

    // ------------------------------------------------------------------
    // Model: every rising edge gets a global index; the inputs seen at that
    // edge are logged. A data output shows the value logged S-1 edges ago,
    // provided that edge came after the most recent moment Reset was high.
    // Reset_Sync is 1 while Reset is high and for S-1 edges after release.
    // ------------------------------------------------------------------
    int  edge_n  = 0;
    int  last_hi = 0;
    bit  log_sens [0:1023];
    bit  log_walk [0:1023];
    bit  log_prog [0:1023];

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        log_sens[edge_n] = Sensor;
        log_walk[edge_n] = Walk_Request;
        log_prog[edge_n] = Reprogram;
        if (Reset) last_hi = edge_n;
    end

    always @(posedge Reset) begin
        last_hi = edge_n;
    end

    function automatic logic exp_data(input int s, input int which);
        int src;
        src = edge_n - s + 1;
        if (Reset || src <= last_hi) return 1'b0;
        case (which)
            0:       return log_sens[src];
            1:       return log_walk[src];
            default: return log_prog[src];
        endcase
    endfunction

    function automatic logic exp_rst(input int s);
        if (Reset) return 1'b1;
        return ((edge_n - last_hi) < s) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_inst(input int s, input logic rs, input logic ss,
                              input logic ws, input logic ps);
        string tag;
        tag = (s == 2) ? "s2" : "s3";
        check({tag, ".Reset_Sync"},  rs, exp_rst(s));
        check({tag, ".Sensor_Sync"}, ss, exp_data(s, 0));
        check({tag, ".WR_Sync"},     ws, exp_data(s, 1));
        check({tag, ".Prog_Sync"},   ps, exp_data(s, 2));
    endtask

    // Per-cycle compare, 3 ns after each rising edge (clear of stimulus).
    always @(posedge clk) begin
        #3;
        if (edge_n >= 2) check_inst(2, r2, s2, w2, p2);
        if (edge_n >= 3) check_inst(3, r3, s3, w3, p3);
    end

    task automatic at(input int t);
        if ($time < t) #(t - $time);
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        // Power-up, all inputs low: settled to zero by 25 ns.
        at(26);
        check("pwr.Reset_Sync", r2, 1'b0);
        check("pwr.Sensor_Sync", s2, 1'b0);
        check("pwr.WR_Sync", w2, 1'b0);
        check("pwr.Prog_Sync", p2, 1'b0);

        // Reset with all data inputs high: bridge asserts without an edge.
        at(50);
        Reset = 1'b1; Sensor = 1'b1; Walk_Request = 1'b1; Reprogram = 1'b1;
        #1;
        check("async.Reset_Sync2", r2, 1'b1);
        check("async.Reset_Sync3", r3, 1'b1);
        at(99);
        check("hold.Sensor_Sync", s2, 1'b0);
        check("hold.WR_Sync", w2, 1'b0);
        check("hold.Prog_Sync", p2, 1'b0);

        // Release at 100: outputs change on the edge at 115, not 105.
        at(100);
        Reset = 1'b0;
        at(112);
        check("rel105.Reset_Sync", r2, 1'b1);
        check("rel105.Sensor_Sync", s2, 1'b0);
        at(116);
        check("rel115.Reset_Sync", r2, 1'b0);
        check("rel115.Sensor_Sync", s2, 1'b1);
        check("rel115.WR_Sync", w2, 1'b1);
        check("rel115.Prog_Sync", p2, 1'b1);

        at(150);
        Sensor = 1'b0; Walk_Request = 1'b0; Reprogram = 1'b0;

        // Sensor latency: 202 rise seen at 215, not 205.
        at(202);
        Sensor = 1'b1;
        at(206);
        check("sens205", s2, 1'b0);
        at(216);
        check("sens215", s2, 1'b1);
        check("sens215.WR_Sync", w2, 1'b0);
        at(302);
        Sensor = 1'b0;
        at(306);
        check("sens305", s2, 1'b1);
        at(316);
        check("sens315", s2, 1'b0);

        // Short walk pulse, then reset before it reaches the output.
        at(400);
        Walk_Request = 1'b1;
        at(410);
        Walk_Request = 1'b0;
        Reset = 1'b1;
        #1;
        check("walk.Reset_Sync", r2, 1'b1);
        check("walk.WR_Sync", w2, 1'b0);
        at(416);
        check("walk416.WR_Sync", w2, 1'b0);

        // STAGES=3: reprogram at 502 appears at 525.
        at(450);
        Reset = 1'b0;
        at(502);
        Reprogram = 1'b1;
        at(516);
        check("s3.prog515", p3, 1'b0);
        check("s2.prog515", p2, 1'b1);
        at(526);
        check("s3.prog525", p3, 1'b1);

        // STAGES=3 release at 600: Reset_Sync falls at 625.
        at(560);
        Reset = 1'b1;
        at(600);
        Reset = 1'b0;
        at(616);
        check("s2.rst615", r2, 1'b0);
        check("s3.rst615", r3, 1'b1);
        at(626);
        check("s3.rst625", r3, 1'b0);
        check("s3.prog625", p3, 1'b1);

        at(700);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_input_synchronizer
`default_nettype wire

// File: doc/input_synchronizer.md
Name: input_synchronizer

Overview:
- Brings the four asynchronous external inputs of the traffic-light controller (Reset, Sensor, Walk_Request, Reprogram) into the clk domain.
- Uses per-signal multi-flop synchronizer chains.
- Sits between the top-level pins and the FSM, timer and walk-register logic, which consume only the *_Sync outputs.
- Reset_Sync is a reset-bridge output: asynchronous assert, synchronous deassert.

Parameters:
- STAGES, 2, number of flip-flops per synchronizer chain; legal range 2..4.

Ports:
- clk  input  1  system clock; all flops rising-edge triggered.
- Reset  input  1  asynchronous active-high reset, also the source of Reset_Sync.
- Sensor  input  1  asynchronous car-sensor input.
- Walk_Request  input  1  asynchronous pedestrian walk-button input.
- Reprogram  input  1  asynchronous timing-reprogram request.
- Prog_Sync  output  1  synchronized Reprogram.
- WR_Sync  output  1  synchronized Walk_Request.
- Sensor_Sync  output  1  synchronized Sensor.
- Reset_Sync  output  1  synchronized reset for downstream logic.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high.
- Reset asserted (high):
  - every flop in the Sensor, Walk_Request and Reprogram chains clears immediately, with no clock edge needed;
  - Prog_Sync, WR_Sync and Sensor_Sync = 0 for as long as Reset is high;
  - every flop in the reset chain sets immediately, so Reset_Sync = 1 within the same delta, asynchronously.
- Reset deassert (Reset falls):
  - reset chain shifts in 0 on each rising clk edge;
  - Reset_Sync falls on the STAGES-th rising edge after Reset is low (2nd edge at default);
  - deassert is always edge-aligned, never glitching.
- Data chains (Reset low): stage0 <= input, stage[i] <= stage[i-1] on each rising edge; output = stage[STAGES-1].
- Latency: an input change that is stable before a rising edge appears at the output on the STAGES-th rising edge, counting that edge as the first (2 edges at default).
- Pulses shorter than one clk period may be lost. No edge detection and no stretching; outputs are level copies.
- Reset reasserted mid-propagation: all in-flight data is discarded, outputs return to 0, and Reset_Sync returns to 1 at once.
- Simultaneous data change and Reset deassert: data chains begin sampling on the first edge with Reset low. Data outputs may therefore become valid while Reset_Sync is still 1; downstream logic must gate on Reset_Sync.
- The chains are independent; no cross-signal coherency is guaranteed.
- No combinational path from any input to any output, except the Reset -> Reset_Sync async assert.
- Flops carry synthesis "async register" / no-retiming attributes. No logic between stages.

Decomposition:
- Shared package: constant DEFAULT_SYNC_STAGES = 2. No typedefs needed.
- Natural sub-module: sync_chain, with parameters STAGES and RESET_VALUE and ports clk, Reset, d, q.
- input_synchronizer instantiates sync_chain four times:
  - three with RESET_VALUE=0 and d = the data input;
  - one for the reset bridge with RESET_VALUE=1 and d = 1'b0.

Test Plan:
- Use a 10 ns clk with rising edges at 5, 15, 25, ... ns.
- Power-up with all inputs 0 and STAGES=2 -> by 25 ns all four outputs = 0; no X after the second edge.
- At 50 ns set Reset=1 with Sensor, Walk_Request and Reprogram all 1 -> Reset_Sync=1 at 50 ns with no edge needed; Sensor_Sync, WR_Sync and Prog_Sync stay 0 while Reset is held.
- Reset=1 until 100 ns, then 0, with the data inputs still 1:
  - data outputs rise at 115 ns (2nd edge after release);
  - Reset_Sync falls at 115 ns.
- Reset low; Sensor 0->1 at 202 ns -> Sensor_Sync=1 at 215 ns, not at 205 ns. Sensor 1->0 at 302 ns -> Sensor_Sync=0 at 315 ns. Other outputs unchanged.
- Walk_Request high for 10 ns spanning the edge at 405 ns, then Reset=1 at 410 ns -> WR_Sync never reaches 1, or is cleared at 410 ns; Reset_Sync=1 at 410 ns.
- STAGES=3 build: Reprogram 0->1 at 502 ns -> Prog_Sync=1 at 525 ns. Reset release at 600 ns -> Reset_Sync falls at 625 ns.
